// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the transmit-feeder issue-state encoding.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    HOLD
  } feeder_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte register array: synchronous write port, asynchronous read at rd_ptr.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_ptr,
  input  logic [UART_BYTE_W-1:0] wr_dat,
  input  logic [AW-1:0]          rd_ptr,
  output logic [UART_BYTE_W-1:0] rd_dat
);

  // Storage is intentionally not reset; occupancy is tracked by the owner.
  logic [UART_BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO and issue FSM feeding the UART transmitter's vld/dat/bsy handshake.
// Optional sticky overflow flag enabled by defining UART_TX_FEEDER_OVF_EN.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_vld,
  input  logic [UART_BYTE_W-1:0] wr_dat,
  output logic                   wr_rdy,
  output logic                   tx_vld,
  output logic [UART_BYTE_W-1:0] tx_dat,
  input  logic                   tx_bsy,
  output logic [AW:0]            count,
  output logic                   empty,
  output logic                   full,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  feeder_state_e state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;
  logic          push;
  logic          handoff;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign wr_rdy  = ~full;
  assign push    = wr_vld & wr_rdy;
  assign handoff = tx_vld & ~tx_bsy;

  always_comb begin
    count_nxt = count;
    if (push && !handoff) begin
      count_nxt = count + 1'b1;
    end else if (!push && handoff) begin
      count_nxt = count - 1'b1;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk    (clk),
    .wr_en  (push & rstn),
    .wr_ptr (wr_ptr),
    .wr_dat (wr_dat),
    .rd_ptr (rd_ptr),
    .rd_dat (tx_dat)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (handoff) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
    end
  end

  // HOLD covers the transmitter's registered bsy so a byte is never offered twice.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      tx_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0 || push) begin
            state  <= PRESENT;
            tx_vld <= 1'b1;
          end
        end
        PRESENT: begin
          if (handoff) begin
            state  <= HOLD;
            tx_vld <= 1'b0;
          end
        end
        HOLD: begin
          if (count_nxt != '0) begin
            state  <= PRESENT;
            tx_vld <= 1'b1;
          end else begin
            state  <= IDLE;
            tx_vld <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          tx_vld <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TX_FEEDER_OVF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (wr_vld && full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder with a simple transmitter bsy model.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
`ifdef UART_TX_FEEDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic         wr_vld;
  logic [7:0]   wr_dat;
  logic         wr_rdy;
  logic         tx_vld;
  logic [7:0]   tx_dat;
  logic         tx_bsy;
  logic [AW:0]  count;
  logic         empty;
  logic         full;
  logic         ovf;
  logic         ovf_clr;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  logic [7:0]   got_q[$];
  logic [7:0]   exp_q[$];
  bit           bsy_model  = 1'b0;
  int unsigned  bsy_cnt    = 0;
  bit           hand_now   = 1'b0;
  bit           was_vld_bsy = 1'b0;
  int unsigned  drops      = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .wr_vld  (wr_vld),
    .wr_dat  (wr_dat),
    .wr_rdy  (wr_rdy),
    .tx_vld  (tx_vld),
    .tx_dat  (tx_dat),
    .tx_bsy  (tx_bsy),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are stable at negedge, so the handshake seen there is the one taken at the next posedge.
  task automatic tick();
    @(negedge clk);
    hand_now = 1'b0;
    if (rstn && was_vld_bsy && !tx_vld) drops++;
    if (rstn && tx_vld && !tx_bsy) begin
      got_q.push_back(tx_dat);
      hand_now = 1'b1;
    end
    was_vld_bsy = tx_vld && tx_bsy;
    @(posedge clk);
    #1;
    if (bsy_model) begin
      if (hand_now) bsy_cnt = 20;
      else if (bsy_cnt != 0) bsy_cnt--;
      tx_bsy = (bsy_cnt != 0);
    end
  endtask

  initial begin
    rstn    = 1'b0;
    wr_vld  = 1'b1;
    wr_dat  = 8'hAA;
    tx_bsy  = 1'b0;
    ovf_clr = 1'b0;

    // Reset while wr_vld is asserted
    tick();
    tick();
    check_eq("rst_count",  32'(count),  0);
    check_eq("rst_tx_vld", 32'(tx_vld), 0);
    check_eq("rst_wr_rdy", 32'(wr_rdy), 1);
    check_eq("rst_ovf",    32'(ovf),    0);
    check_eq("rst_empty",  32'(empty),  1);
    check_eq("rst_full",   32'(full),   0);
    rstn   = 1'b1;
    wr_vld = 1'b0;
    tick();
    check_eq("rst_no_push_count", 32'(count), 0);
    check_eq("rst_no_push_vld",   32'(tx_vld), 0);

    // Single byte, transmitter idle
    wr_vld = 1'b1;
    wr_dat = 8'h55;
    tick();
    wr_vld = 1'b0;
    check_eq("one_tx_vld", 32'(tx_vld), 1);
    check_eq("one_tx_dat", 32'(tx_dat), 32'h55);
    check_eq("one_count",  32'(count),  1);
    tick();
    check_eq("one_hold_vld", 32'(tx_vld), 0);
    check_eq("one_count0",   32'(count),  0);
    check_eq("one_nhand",    got_q.size(), 1);
    if (got_q.size() > 0) check_eq("one_byte", 32'(got_q[0]), 32'h55);
    got_q.delete();

    // Three bytes throttled by a 20-cycle busy after each handoff
    bsy_model = 1'b1;
    drops     = 0;
    for (int i = 1; i <= 3; i++) begin
      wr_vld = 1'b1;
      wr_dat = 8'(i);
      tick();
    end
    wr_vld = 1'b0;
    for (int c = 0; c < 200 && !(got_q.size() == 3 && empty && !tx_vld); c++) tick();
    check_eq("bsy_nhand", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      check_eq($sformatf("bsy_byte%0d", i), 32'(got_q[i]), 32'(i + 1));
    check_eq("bsy_vld_drops", drops, 0);
    for (int c = 0; c < 30 && bsy_cnt != 0; c++) tick();
    bsy_model = 1'b0;
    tx_bsy    = 1'b0;
    tick();
    check_eq("bsy_count0", 32'(count), 0);
    got_q.delete();

    // Fill to DEPTH and overrun by one, transmitter busy
    tx_bsy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_vld = 1'b1;
      wr_dat = 8'h10 + 8'(i);
      tick();
      if (i == 15) begin
        check_eq("fill_full",   32'(full),   1);
        check_eq("fill_count",  32'(count),  16);
        check_eq("fill_wr_rdy", 32'(wr_rdy), 0);
      end
    end
    wr_vld = 1'b0;
    check_eq("ovr_count", 32'(count), 16);
    check_eq("ovr_ovf",   32'(ovf),   32'(OVF_EN));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("ovr_ovf_clr", 32'(ovf), 0);

    // Push and handoff in the same cycle while full
    tx_bsy = 1'b0;
    wr_vld = 1'b1;
    wr_dat = 8'h2F;
    tick();
    check_eq("both_count",   32'(count), 15);
    check_eq("both_nhand",   got_q.size(), 1);
    wr_dat = 8'h30;
    tick();
    wr_vld = 1'b0;
    check_eq("refill_count", 32'(count), 16);
    for (int c = 0; c < 100 && !(empty && !tx_vld); c++) tick();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
    exp_q.push_back(8'h30);
    check_eq("drain_nhand", got_q.size(), 17);
    for (int i = 0; i < 17 && i < got_q.size(); i++)
      check_eq($sformatf("drain_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    got_q.delete();

    // Reset while presenting with five bytes buffered
    tx_bsy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_vld = 1'b1;
      wr_dat = 8'hA0 + 8'(i);
      tick();
    end
    wr_vld = 1'b0;
    check_eq("mid_count", 32'(count),  5);
    check_eq("mid_vld",   32'(tx_vld), 1);
    rstn = 1'b0;
    tick();
    check_eq("mid_rst_count",  32'(count),  0);
    check_eq("mid_rst_vld",    32'(tx_vld), 0);
    check_eq("mid_rst_empty",  32'(empty),  1);
    check_eq("mid_rst_wr_rdy", 32'(wr_rdy), 1);
    rstn = 1'b1;
    tick();
    check_eq("mid_idle_vld",   32'(tx_vld), 0);
    check_eq("mid_idle_count", 32'(count),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte buffer and issue controller directly upstream of the UART transmitter. Accepts bytes from the CPU/MMIO side through a valid/ready write port, stores them in a DEPTH-entry FIFO, and presents them one at a time on the transmitter's `vld`/`dat`/`bsy` handshake. It guarantees that each stored byte is handed off exactly once, despite the one-cycle registered latency of the transmitter's `bsy`.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `AW`, 4: pointer width, equal to log2(DEPTH).
- `clk`  in  1  clock.
- `rstn`  in  1  reset; one clock, synchronous, active-low.
- `wr_vld`  in  1  write request.
- `wr_dat`  in  8  write byte.
- `wr_rdy`  out  1  FIFO can accept a byte.
- `tx_vld`  out  1  byte offered to the transmitter; drives its `vld`.
- `tx_dat`  out  8  offered byte; drives its `dat`.
- `tx_bsy`  in  1  transmitter busy; driven from its `bsy`.
- `count`  out  AW+1  occupancy, 0..DEPTH.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `ovf`  out  1  sticky overflow flag; see Configuration.
- `ovf_clr`  in  1  clears `ovf`.

## Operation
- Push occurs when `wr_vld & wr_rdy`. The byte is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- `wr_rdy = ~full`. `wr_rdy` comes from registered count only; a pop in the same cycle does not free a slot for that cycle's push.
- Handoff occurs when `tx_vld & ~tx_bsy`. `rd_ptr` increments modulo DEPTH.
- `count` next value: +1 on push only, -1 on handoff only, unchanged when both or neither occur.
- `tx_dat = mem[rd_ptr]`, driven combinationally from the register array. It is stable whenever `tx_vld` = 1.
- Issue FSM, three states; `tx_vld` = 1 only in PRESENT:
  - IDLE: go to PRESENT if (count != 0) or push; otherwise stay.
  - PRESENT: on handoff go to HOLD; otherwise stay.
  - HOLD: lasts one cycle and covers the transmitter's `bsy` register latency. Go to PRESENT if next count != 0; otherwise go to IDLE.
- Write when full: the byte is dropped and FIFO contents are unchanged.
- No bypass. A byte pushed into an empty FIFO is never offered in its push cycle.
- Pointer wrap: pointers are AW bits. Full and empty are decided by `count`, never by pointer compare.
- Reset values: `wr_ptr`, `rd_ptr`, `count` = 0; state = IDLE; `tx_vld` = 0; `wr_rdy` = 1; `empty` = 1; `full` = 0; `ovf` = 0.
- FIFO memory is not reset. `tx_dat` is don't-care while `tx_vld` = 0.
- Reset mid-operation discards all buffered bytes. A byte already accepted by the transmitter is not recalled.

## Timing
- Push in cycle N into an empty, idle block: `count` = 1 and `tx_vld` = 1 at N+1.
- Handoff in cycle T: `tx_vld` = 0 at T+1 (HOLD). Earliest next `tx_vld` is T+2.
- A backlog therefore gives at most one handoff every 2 cycles. In practice the transmitter's `bsy` throttles to one handoff per frame.
- `tx_vld` stays high until handoff. It never drops while `tx_bsy` = 1 in PRESENT.
- `count`, `empty`, `full` and `wr_rdy` are all registered or derived from registered `count`; none has a combinational path from `wr_vld` or `tx_bsy`.

## Configuration
- `UART_TX_FEEDER_OVF_EN` defined:
  - `ovf` sets on the cycle after `wr_vld & full`.
  - `ovf` stays set until `ovf_clr` = 1.
  - Set wins over clear in the same cycle.
- Not defined: `ovf` is tied to 0 and `ovf_clr` is ignored. Data behaviour is identical in both builds.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_BYTE_W` = 8;
  - the feeder state enum (IDLE, PRESENT, HOLD).
- One sub-module, `uart_fifo_mem`: DEPTH x 8 register array with write port and asynchronous read at `rd_ptr`.
- Pointers, count and the FSM stay in `uart_tx_feeder`.

## Test plan
- Reset with `wr_vld` = 1 → `count` = 0, `tx_vld` = 0, `wr_rdy` = 1, `ovf` = 0; no push is recorded.
- Push 0x55 at cycle N, with `tx_bsy` held 0 → `tx_vld` = 1 and `tx_dat` = 0x55 at N+1; handoff at N+1; `tx_vld` = 0 at N+2; `count` = 0.
- Push 0x01, 0x02, 0x03 back-to-back. Model `tx_bsy` as 1 from the cycle after each handoff for 20 cycles → 0x01, 0x02, 0x03 each accepted exactly once, in order; no handoff while `tx_bsy` = 1.
- Push 17 bytes, `tx_bsy` = 1 → `full` = 1 after 16 pushes; `wr_rdy` = 0; 17th byte dropped. With the macro, `ovf` = 1; `ovf_clr` then returns it to 0. Without the macro, `ovf` stays 0.
- Full FIFO with push and handoff in the same cycle → push rejected, `count` = 15. Push next cycle → accepted, `count` = 16. Pointers wrap and bytes drain in FIFO order.
- Assert `rstn` = 0 with `count` = 5 while in PRESENT → next cycle `count` = 0, state IDLE, `tx_vld` = 0.
